// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder: FSM encoding and
// elaboration-time helpers for lane depth and packed lane slicing.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Larger of two integers; sizes the drain so the deepest lane empties.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // LSB position of lane 'lane' inside a packed vector of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_lane.sv
// One skew lane: a DEPTH-stage shift register carrying data plus a valid bit.
// Bubbles enter as zero data with valid low so the PE edge never sees stale values.
module skew_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         in_vld,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_vld
);

  logic signed [DATA_WIDTH-1:0] data_p [DEPTH];
  logic        [DEPTH-1:0]      vld_p;

  // Shift one stage per advance; clear wipes every stage regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) data_p[j] <= '0;
      vld_p <= '0;
    end else if (clr) begin
      for (int j = 0; j < DEPTH; j++) data_p[j] <= '0;
      vld_p <= '0;
    end else if (en) begin
      data_p[0] <= in_vld ? in_data : '0;
      vld_p[0]  <= in_vld;
      for (int j = 1; j < DEPTH; j++) begin
        data_p[j] <= data_p[j-1];
        vld_p[j]  <= vld_p[j-1];
      end
    end
  end

  assign out_data = data_p[DEPTH-1];
  assign out_vld  = vld_p[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Systolic array input controller: accepts A row-vectors and B column-vectors
// with a valid/ready handshake and skews lane k by k extra beats. A tile ends
// on in_last, after which bubbles are pushed until the deepest lane has
// delivered the final beat (done), then the controller returns to IDLE.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [DATA_WIDTH*ROWS-1:0] A,
  input  logic [DATA_WIDTH*COLS-1:0] B,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*ROWS-1:0] A_out,
  output logic [DATA_WIDTH*COLS-1:0] B_out,
  output logic [ROWS-1:0]            a_lane_valid,
  output logic [COLS-1:0]            b_lane_valid,
  output logic                       valid,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           beat_cnt
);

  localparam int MAXD   = max_int(ROWS, COLS);
  localparam int DCNT_W = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'(MAXD - 1);

  state_t              state;
  logic [DCNT_W-1:0]   dcnt;
  logic                advance;
  logic                accept;

  // The array's stall gates everything; flush also blocks new beats so a
  // beat presented alongside flush is dropped rather than half-loaded.
  assign advance  = out_ready;
  assign in_ready = out_ready && (state != DRAIN) && !flush;
  assign accept   = in_valid && in_ready;

  // Tile framing: count beats, then drain MAXD-1 bubbles past the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dcnt     <= '0;
      beat_cnt <= '0;
    end else if (flush) begin
      state    <= IDLE;
      dcnt     <= '0;
      beat_cnt <= '0;
    end else if (advance) begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            beat_cnt <= CNT_W'(1);
            if (in_last) begin
              state <= DRAIN;
              dcnt  <= DCNT_INIT;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (in_last) begin
              state <= DRAIN;
              dcnt  <= DCNT_INIT;
            end
          end
        end
        DRAIN: begin
          if (dcnt == '0) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else begin
            dcnt <= dcnt - DCNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          dcnt     <= '0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Status comes straight from registers, so done holds through a stall.
  assign busy  = (state != IDLE);
  assign done  = (state == DRAIN) && (dcnt == '0);
  assign valid = (|a_lane_valid) || (|b_lane_valid);

  for (genvar k = 0; k < ROWS; k++) begin : g_a_lane
    skew_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (k + 1)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .en      (advance),
      .in_vld  (accept),
      .in_data (A[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .out_data(A_out[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .out_vld (a_lane_valid[k])
    );
  end

  for (genvar k = 0; k < COLS; k++) begin : g_b_lane
    skew_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (k + 1)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .en      (advance),
      .in_vld  (accept),
      .in_data (B[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .out_data(B_out[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .out_vld (b_lane_valid[k])
    );
  end

endmodule
